// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared widths and requester indices for the writeback arbiter
package regfile_write_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGISTERS_LOG2 = 5;
  localparam int NUM_REQ = 4;
  localparam int REQ_ALU0 = 0;
  localparam int REQ_ALU1 = 1;
  localparam int REQ_LOAD = 2;
  localparam int REQ_MULDIV = 3;
  localparam int CONFLICT_CNT_WIDTH = 16;
endpackage

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
// rr_priority_pick: first set request at or after start, wrapping, as one-hot grant plus index
module rr_priority_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         found
);
  logic [W-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(start) + k) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: grants up to two conflict-free writebacks per cycle onto registered write ports
module regfile_write_arbiter #(
  parameter int NUM_REQ = regfile_write_arbiter_pkg::NUM_REQ,
  parameter int DATA_WIDTH = regfile_write_arbiter_pkg::DATA_WIDTH,
  parameter int NUM_REGISTERS_LOG2 = regfile_write_arbiter_pkg::NUM_REGISTERS_LOG2,
  parameter bit ZERO_REG_DISCARD = 1'b1
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [NUM_REQ-1:0]                              req_valid,
  input  logic [NUM_REQ*NUM_REGISTERS_LOG2-1:0]           req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                   req_data,
  output logic [NUM_REQ-1:0]                              req_ready,
  output logic                                            write1,
  output logic [NUM_REGISTERS_LOG2-1:0]                   write_address1,
  output logic [DATA_WIDTH-1:0]                           write_data1,
  output logic                                            write2,
  output logic [NUM_REGISTERS_LOG2-1:0]                   write_address2,
  output logic [DATA_WIDTH-1:0]                           write_data2,
  output logic [regfile_write_arbiter_pkg::CONFLICT_CNT_WIDTH-1:0] conflict_count
);
  import regfile_write_arbiter_pkg::*;
  localparam int PW = $clog2(NUM_REQ);
  localparam int AW = NUM_REGISTERS_LOG2;
  localparam int DW = DATA_WIDTH;
  localparam int CW = CONFLICT_CNT_WIDTH;
  logic [AW-1:0] addr [NUM_REQ];
  logic [DW-1:0] data [NUM_REQ];
  logic [NUM_REQ-1:0] cand, zero_req, same, mask_b, grant_a, grant_b;
  logic [PW-1:0] idx_a, idx_b, last;
  logic a_found, b_found, conflict;
  logic write1_q, write1_d, write2_q, write2_d;
  logic [AW-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DW-1:0] data1_q, data1_d, data2_q, data2_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cc_q, cc_d;
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr[i] = req_addr[i*AW +: AW];
      data[i] = req_data[i*DW +: DW];
      cand[i] = req_valid[i] && !(ZERO_REG_DISCARD && addr[i] == '0);
    end
  end
  assign zero_req = req_valid & ~cand;
  rr_priority_pick #(.N(NUM_REQ)) u_pick_a (
    .req(cand), .start(rr_ptr_q), .grant(grant_a), .idx(idx_a), .found(a_found)
  );
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) same[i] = cand[i] && !grant_a[i] && addr[i] == addr[idx_a];
  end
  assign mask_b = cand & ~grant_a & ~same;
  // Nothing between rr_ptr and A is a candidate, so B can scan from rr_ptr as well.
  rr_priority_pick #(.N(NUM_REQ)) u_pick_b (
    .req(mask_b), .start(rr_ptr_q), .grant(grant_b), .idx(idx_b), .found(b_found)
  );
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (same[i] && (!b_found || (i - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ
                                  < (int'(idx_b) - int'(rr_ptr_q) + NUM_REQ) % NUM_REQ))
        conflict = 1'b1;
  end
  assign req_ready = reset ? (zero_req | grant_a | grant_b) : '0;
  always_comb begin
    write1_d = a_found;
    addr1_d = a_found ? addr[idx_a] : addr1_q;
    data1_d = a_found ? data[idx_a] : data1_q;
    write2_d = b_found;
    addr2_d = b_found ? addr[idx_b] : addr2_q;
    data2_d = b_found ? data[idx_b] : data2_q;
    last = b_found ? idx_b : idx_a;
    rr_ptr_d = !a_found ? rr_ptr_q : (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
    cc_d = (conflict && cc_q != '1) ? cc_q + 1'b1 : cc_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write1_q <= 1'b0;
      addr1_q <= '0;
      data1_q <= '0;
      write2_q <= 1'b0;
      addr2_q <= '0;
      data2_q <= '0;
      rr_ptr_q <= '0;
      cc_q <= '0;
    end else begin
      write1_q <= write1_d;
      addr1_q <= addr1_d;
      data1_q <= data1_d;
      write2_q <= write2_d;
      addr2_q <= addr2_d;
      data2_q <= data2_d;
      rr_ptr_q <= rr_ptr_d;
      cc_q <= cc_d;
    end
  end
  assign write1 = write1_q;
  assign write_address1 = addr1_q;
  assign write_data1 = data1_q;
  assign write2 = write2_q;
  assign write_address2 = addr2_q;
  assign write_data2 = data2_q;
  assign conflict_count = cc_q;
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's two write ports (write1/write2) among NUM_REQ writeback requesters: ALU0, ALU1, load unit and mult/div.
- Each cycle it grants up to two requests using rotating priority and never grants two requests to the same address in one cycle.
- Granted writes are registered, so they reach the register file one cycle after acceptance.
- Sits between the execute/memory stages and the register file; it is the only driver of the register file write ports.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- DATA_WIDTH, 32, register data width.
- NUM_REGISTERS_LOG2, 5, register address width.
- ZERO_REG_DISCARD, 1, if 1, writes to address 0 are accepted but never forwarded to a port.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*NUM_REGISTERS_LOG2  packed destination addresses; requester i occupies slice i.
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  combinational grant; a transfer occurs when valid and ready are both 1.
- write1, write_address1, write_data1  out  1/NUM_REGISTERS_LOG2/DATA_WIDTH  registered port-1 write.
- write2, write_address2, write_data2  out  1/NUM_REGISTERS_LOG2/DATA_WIDTH  registered port-2 write.
- conflict_count  out  16  saturating count of cycles in which any request was denied only because of a same-address conflict.

Behaviour:
- Requester contract: hold valid, addr and data stable until ready is seen. The arbiter makes no assumption about request ordering.
- rr_ptr (log2 NUM_REQ bits) resets to 0.
- Scan order is rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ.
- Zero-address requests (ZERO_REG_DISCARD=1, addr==0):
  - ready=1 whenever valid.
  - No port consumed, no effect on rr_ptr, no write issued.
- Slot A = first valid non-discarded request in scan order. Its ready=1.
- Slot B = next valid non-discarded request after A whose addr differs from A's addr. Its ready=1.
- Every other request has ready=0.
- A request is "conflict-denied" when it is valid, not granted, and its addr equals slot A's addr, and it would otherwise have taken slot B. A conflict-denied request causes no further grant that cycle.
- Output stage, on the next clk edge:
  - write1 <= (slot A exists), with A's addr/data.
  - write2 <= (slot B exists), with B's addr/data.
  - When no grant, write1/write2 go to 0; addr/data values are don't-care but must be held.
  - Latency is exactly 1 cycle from handshake to port assertion.
- rr_ptr update:
  - If any slot was granted, rr_ptr <= (index of last granted slot + 1) mod NUM_REQ.
  - Otherwise rr_ptr holds.
  - Guarantee: a continuously valid request is granted within NUM_REQ cycles.
- conflict_count: increments by 1 in each cycle with at least one conflict-denied request; saturates at 16'hFFFF.
- Same-cycle same-address writes never reach the register file, so write1/write2 ordering inside the register file is irrelevant.
- Reset assertion, including mid-operation, acts immediately (asynchronously):
  - write1, write2, write_address*, write_data*, rr_ptr and conflict_count go to 0.
  - req_ready is forced to 0 while reset is low.
  - Any grant in flight is dropped.
- First grants are possible in the first cycle after reset deasserts.

Decomposition:
- Shared package holds:
  - width constants: DATA_WIDTH, NUM_REGISTERS_LOG2, NUM_REQ defaults;
  - requester index constants: REQ_ALU0=0, REQ_ALU1=1, REQ_LOAD=2, REQ_MULDIV=3;
  - CONFLICT_CNT_WIDTH=16.
- One sub-module, rr_priority_pick: combinational rotating-priority finder (request mask, start pointer -> one-hot grant + index).
  - Instance 1 picks slot A.
  - Instance 2 picks slot B using the mask minus A minus same-address requests.

Test Plan:
- Reset low, all valid=1 -> ready=0000, all outputs 0. Release reset, req0 addr3/req1 addr4 -> ready=0011; next cycle write1=1 addr3, write2=1 addr4; rr_ptr=2.
- req0 and req1 both addr 7, data 0xA / 0xB, ptr=0 -> ready=0001. Next cycle write1 addr7 data 0xA, write2=0, conflict_count=1. Following cycle req1 is granted on write1 with data 0xB.
- All four valid on distinct addresses, held 2 cycles -> cycle 1 grants {0,1}, cycle 2 grants {2,3}; rr_ptr returns to 0.
- req2 addr 0 with req0 addr 5 -> ready=0101; only write1 addr5 asserted; rr_ptr=1.
- Hold a conflict-denied request for 70000 cycles -> conflict_count saturates at 0xFFFF and does not wrap.
- Assert reset mid-cycle while write1=1 -> write1 drops before the next clk edge; conflict_count=0; no write issued after release until a new handshake.
